// File: rtl/mul_share_pkg.sv
// Shared defaults and helpers for the arbitrated truncating multiplier.
package mul_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 12;
  localparam int IDW_DEF  = $clog2(NREQ_DEF);

  // Width of the truncation register and its value out of reset.
  localparam int            TW    = 4;
  localparam logic [TW-1:0] T_RST = 4'd6;

  // Clamp the programmed truncation so at least the operand MSB survives.
  function automatic logic [TW-1:0] clamp_t(input logic [TW-1:0] t, input int w);
    if (int'(t) > w - 1) return TW'(w - 1);
    return t;
  endfunction

endpackage

// File: rtl/mul12_trunc_pipe.sv
// Two-stage truncate-and-multiply pipeline with valid/ready handshakes and
// an ID sideband. Stage 1 holds masked operands, stage 2 holds the product.
module mul12_trunc_pipe
  import mul_share_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int IDW = IDW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [W-1:0]     i_in_a,
  input  logic [W-1:0]     i_in_b,
  input  logic [TW-1:0]    i_in_t,
  input  logic [IDW-1:0]   i_in_id,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [IDW-1:0]   o_out_id,
  output logic [2*W-1:0]   o_out_z,
  output logic             o_busy
);

  logic             r_s1_valid;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic [IDW-1:0]   r_s1_id;
  logic             r_s2_valid;
  logic [2*W-1:0]   r_s2_z;
  logic [IDW-1:0]   r_s2_id;

  logic             w_s2_free;
  logic [W-1:0]     w_mask;
  logic [W-1:0]     w_a_trunc;
  logic [W-1:0]     w_b_trunc;

  // Stage 2 can take new data when empty or when its result leaves this cycle;
  // stage 1 can accept when empty or when it is moving into stage 2.
  assign w_s2_free  = !r_s2_valid || i_out_ready;
  assign o_in_ready = !r_s1_valid || w_s2_free;

  // Truncation is applied at accept, so the mask travels with the operands.
  assign w_mask    = {W{1'b1}} << i_in_t;
  assign w_a_trunc = i_in_a & w_mask;
  assign w_b_trunc = i_in_b & w_mask;

  // Stage 1: capture truncated operands and requester ID on accept.
  // NOTE: datapath registers are reset too, so outputs read as zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
    end else if (o_in_ready) begin
      // NOTE: sequential state uses non-blocking assignment so all registers
      // update from the same pre-edge values.
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_a  <= w_a_trunc;
        r_s1_b  <= w_b_trunc;
        r_s1_id <= i_in_id;
      end
    end
  end

  // Stage 2: form the full-width unsigned product; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_z     <= '0;
      r_s2_id    <= '0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_z  <= {{W{1'b0}}, r_s1_a} * {{W{1'b0}}, r_s1_b};
        r_s2_id <= r_s1_id;
      end
    end
  end

  assign o_out_valid = r_s2_valid;
  assign o_out_z     = r_s2_z;
  assign o_out_id    = r_s2_id;
  assign o_busy      = r_s1_valid || r_s2_valid;

endmodule

// File: rtl/mul12_share_arb.sv
// Round-robin arbiter sharing one truncating multiplier among NREQ requesters.
// Holds the truncation config register and the last-granted pointer.
module mul12_share_arb
  import mul_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [TW-1:0]     cfg_trunc,
  input  logic              cfg_we,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_z,
  output logic              busy
);

  logic [IDW-1:0] r_last;
  logic [TW-1:0]  r_t;

  logic           w_any;
  logic [IDW-1:0] w_win;
  logic           w_pipe_ready;
  logic           w_accept;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [TW-1:0]  w_t_eff;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_last) + 1 + k) % NREQ;
      // NOTE: blocking assignment in combinational logic lets later loop
      // iterations see that a winner was already found.
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_win = IDW'(idx);
      end
    end
  end

  // A grant is only a transfer when the pipeline can take it; the reset term
  // keeps req_ready low asynchronously while reset is held.
  assign w_accept = rst_n && w_any && w_pipe_ready;
  assign w_a      = req_a[int'(w_win)*W +: W];
  assign w_b      = req_b[int'(w_win)*W +: W];
  assign w_t_eff  = clamp_t(r_t, W);

  // One-hot ready to the winning requester only.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_win] = 1'b1;
  end

  // Pointer moves only on a real transfer; reset makes the next search start at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= IDW'(NREQ - 1);
    else if (w_accept) r_last <= w_win;
  end

  // Truncation register; an accept in the same cycle still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_t <= T_RST;
    else if (cfg_we) r_t <= cfg_trunc;
  end

  mul12_trunc_pipe #(
    .W   (W),
    .IDW (IDW)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (w_any),
    .o_in_ready  (w_pipe_ready),
    .i_in_a      (w_a),
    .i_in_b      (w_b),
    .i_in_t      (w_t_eff),
    .i_in_id     (w_win),
    .o_out_valid (rsp_valid),
    .i_out_ready (rsp_ready),
    .o_out_id    (rsp_id),
    .o_out_z     (rsp_z),
    .o_busy      (busy)
  );

endmodule

// File: tb/tb_mul12_share_arb.sv
// Scoreboard bench for mul12_share_arb: directed operands with hand-computed
// products; a monitor pops expected responses whenever a result transfers.
module tb_mul12_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_a;
  logic [47:0] req_b;
  logic [3:0]  cfg_trunc;
  logic        cfg_we;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_z;
  logic        busy;

  typedef struct { logic [11:0] a; logic [11:0] b; } op_t;
  typedef struct { logic [1:0] id; logic [23:0] z; } exp_t;

  op_t  src_q[4][$];
  exp_t sb[$];
  logic [3:0] fire_r = '0;
  int n_checks = 0;
  int n_errors = 0;

  mul12_share_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .cfg_trunc (cfg_trunc),
    .cfg_we    (cfg_we),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_op(input int i, input logic [11:0] a, input logic [11:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    src_q[i].push_back(o);
  endtask

  task automatic exp_rsp(input logic [1:0] id, input logic [23:0] z);
    exp_t e;
    e.id = id;
    e.z  = z;
    sb.push_back(e);
  endtask

  task automatic cfg(input logic [3:0] t);
    @(posedge clk); #2;
    cfg_trunc = t;
    cfg_we    = 1'b1;
    @(posedge clk); #2;
    cfg_we    = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_outstanding"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_fire(input int i, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_valid[i] && req_ready[i]) && n < 50);
    check({name, "_accept"}, 32'(req_valid[i] && req_ready[i]), 32'd1);
  endtask

  // Capture which requesters transfer at the coming edge.
  always @(negedge clk) fire_r <= req_valid & req_ready & {4{rst_n}};

  // Driver: present the head of each requester's queue; retire it after transfer.
  initial begin : driver
    op_t head;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (fire_r[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          head = src_q[i][0];
          req_valid[i]       = 1'b1;
          req_a[i*12 +: 12]  = head.a;
          req_b[i*12 +: 12]  = head.b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: compare each transferred result against the scoreboard head and
  // confirm outputs hold while stalled.
  initial begin : monitor
    logic        stall_prev;
    logic [23:0] z_prev;
    logic [1:0]  id_prev;
    exp_t        e;
    stall_prev = 1'b0;
    z_prev     = '0;
    id_prev    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        continue;
      end
      check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (stall_prev) begin
        check("stall_hold_valid", 32'(rsp_valid), 32'd1);
        check("stall_hold_z", 32'(rsp_z), 32'(z_prev));
        check("stall_hold_id", 32'(rsp_id), 32'(id_prev));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got id %0d z 0x%0h, expected no result", rsp_id, rsp_z);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_z", 32'(rsp_z), 32'(e.z));
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      z_prev     = rsp_z;
      id_prev    = rsp_id;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int acc;
    int n;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_trunc = '0;

    // Reset state.
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_z", 32'(rsp_z), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Default truncation of 6: 0x0FF -> 0x0C0, 0x03F -> 0.
    push_op(3, 12'h0FF, 12'h0FF);
    push_op(3, 12'h03F, 12'hFFF);
    exp_rsp(2'd3, 24'h009000);
    exp_rsp(2'd3, 24'h000000);
    drain("trunc_default");

    // Exact products, all requesters busy: grants rotate 0,1,2,3,0,1,2,3.
    cfg(4'd0);
    push_op(0, 12'h002, 12'h003);  push_op(0, 12'h010, 12'h010);
    push_op(1, 12'h005, 12'h007);  push_op(1, 12'h020, 12'h003);
    push_op(2, 12'h0FF, 12'h002);  push_op(2, 12'h100, 12'h100);
    push_op(3, 12'h800, 12'h002);  push_op(3, 12'hFFF, 12'h001);
    exp_rsp(2'd0, 24'h000006);
    exp_rsp(2'd1, 24'h000023);
    exp_rsp(2'd2, 24'h0001FE);
    exp_rsp(2'd3, 24'h001000);
    exp_rsp(2'd0, 24'h000100);
    exp_rsp(2'd1, 24'h000060);
    exp_rsp(2'd2, 24'h010000);
    exp_rsp(2'd3, 24'h000FFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    for (int k = 0; k < 8; k++) begin
      check("throughput_rsp_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    drain("round_robin");

    // Latency: accept at N, result visible at N+2.
    push_op(0, 12'hFFF, 12'hFFF);
    exp_rsp(2'd0, 24'hFFE001);
    wait_fire(0, "latency");
    @(negedge clk);
    check("latency_n1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("latency_n2_rsp_valid", 32'(rsp_valid), 32'd1);
    drain("latency");

    // Backpressure: three pending, consumer stalled for five cycles.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    push_op(1, 12'h003, 12'h004);
    push_op(2, 12'h006, 12'h007);
    push_op(3, 12'h00A, 12'h00B);
    exp_rsp(2'd1, 24'h00000C);
    exp_rsp(2'd2, 24'h00002A);
    exp_rsp(2'd3, 24'h00006E);
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 4'd0) acc++;
    end
    check("stall_accept_count", 32'(acc), 32'd2);
    check("stall_req_ready", 32'(req_ready), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    drain("backpressure");

    // Config written the cycle after an accept leaves that op exact.
    push_op(0, 12'h9AB, 12'hCDE);
    exp_rsp(2'd0, 24'h7C664A);
    wait_fire(0, "cfg_after_accept");
    @(posedge clk); #2;
    cfg_trunc = 4'd11;
    cfg_we    = 1'b1;
    @(posedge clk); #2;
    cfg_we    = 1'b0;
    push_op(0, 12'hFFF, 12'h9AB);
    exp_rsp(2'd0, 24'h400000);
    drain("cfg_t11");

    // Config written in the same cycle as an accept: that op uses the old t.
    push_op(0, 12'hFFF, 12'hFFF);
    exp_rsp(2'd0, 24'h400000);
    @(posedge clk); #2;
    cfg_trunc = 4'd0;
    cfg_we    = 1'b1;
    @(posedge clk); #2;
    cfg_we    = 1'b0;
    drain("cfg_same_cycle_old");
    push_op(0, 12'hFFF, 12'hFFF);
    exp_rsp(2'd0, 24'hFFE001);
    drain("cfg_same_cycle_new");

    // Truncation above W-1 clamps to W-1.
    cfg(4'd15);
    push_op(0, 12'hFFF, 12'hFFF);
    exp_rsp(2'd0, 24'h400000);
    drain("cfg_clamp");

    // Reset with both stages full; pointer left at requester 1 beforehand.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    push_op(1, 12'h123, 12'h456);
    push_op(1, 12'h111, 12'h222);
    repeat (4) @(negedge clk);
    check("full_busy", 32'(busy), 32'd1);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rsp_z", 32'(rsp_z), 32'd0);
    check("async_rst_rsp_id", 32'(rsp_id), 32'd0);
    sb.delete();
    for (int i = 0; i < 4; i++) src_q[i].delete();
    rsp_ready = 1'b1;
    push_op(0, 12'h0FF, 12'h0FF);
    push_op(2, 12'h07F, 12'h041);
    exp_rsp(2'd0, 24'h009000);
    exp_rsp(2'd2, 24'h001000);
    repeat (2) @(negedge clk);
    check("in_rst_req_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b1;
    drain("post_reset");

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
